// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one sequential Booth multiplier between two requesters,
// sequencing load/run timing and returning the ID-tagged product on one response channel.
module booth_mul_arbiter #(
    parameter int N       = 4,
    parameter int MUL_LAT = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_mr,
    input  logic [N-1:0]   req0_md,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_mr,
    input  logic [N-1:0]   req1_md,
    output logic           mul_load,
    output logic [N-1:0]   mul_mr,
    output logic [N-1:0]   mul_md,
    input  logic [2*N-1:0] mul_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_prod,
    output logic           busy
);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            last_grant, grant, grant_vld, accept, cnt_done;

    always_comb begin
        grant_vld  = req0_valid || req1_valid;
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        // ready is gated by rst so it stays low for the whole reset assertion
        req0_ready = rst && (state == IDLE) && grant_vld && !grant;
        req1_ready = rst && (state == IDLE) && grant_vld && grant;
        accept     = req0_ready || req1_ready;
        cnt_done   = cnt == CW'(MUL_LAT - 1);
        mul_load   = state != RUN;
        busy       = state != IDLE;
        state_nxt  = state;
        case (state)
            IDLE:    state_nxt = accept ? LOAD : IDLE;
            LOAD:    state_nxt = RUN;
            RUN:     state_nxt = cnt_done ? DONE : RUN;
            default: state_nxt = rsp_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            mul_mr     <= '0;
            mul_md     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_prod   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == RUN) ? cnt + 1'b1 : '0;
            if (accept) begin
                mul_mr     <= grant ? req1_mr : req0_mr;
                mul_md     <= grant ? req1_md : req0_md;
                rsp_id     <= grant;
                last_grant <= grant;
            end
            if (state == RUN && cnt_done) begin
                rsp_prod  <= mul_out;
                rsp_valid <= 1'b1;
            end
            if (state == DONE && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one sequential Booth multiplier (N-bit signed operands, 2N-bit product) between two requesters.
- Round-robin arbitration selects a requester. The block loads the chosen operands into the multiplier, times its N iterations and captures the product.
- Returns the product on a single response channel, tagged with the requester ID.
- Sits between client logic and the multiplier datapath. It is the only driver of the multiplier's load and operand inputs.

Parameters:
- N, 4, operand width. Product width is 2N.
- MUL_LAT, 5, cycles the multiplier needs after load is released before its output is valid (N+1 for the team's Booth multiplier).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_mr  input  N  requester 0 multiplier, signed.
- req0_md  input  N  requester 0 multiplicand, signed.
- req1_valid, req1_ready, req1_mr, req1_md: same as requester 0, for requester 1.
- mul_load  output  1  drives the multiplier's load/reset input. High means operands are loaded and the datapath is held.
- mul_mr  output  N  multiplier operand to the datapath.
- mul_md  output  N  multiplicand operand to the datapath.
- mul_out  input  2N  product from the datapath.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that owns the result.
- rsp_prod  output  2N  signed product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1, cnt=0.
  - mul_load=1, mul_mr=0, mul_md=0.
  - rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0.
  - req0_ready=0 and req1_ready=0 while rst=0.
- Grant (combinational, IDLE only):
  - Both valid: grant the requester != last_grant.
  - One valid: grant that requester.
  - None valid: no grant.
  - reqX_ready = (state==IDLE) && grant==X. At most one ready is high per cycle.
- Accept:
  - Happens on the edge where reqX_valid && reqX_ready.
  - Registers operands into mul_mr/mul_md and X into rsp_id; sets last_grant=X.
  - Transition IDLE->LOAD.
- LOAD: mul_load=1 for exactly one cycle with the new operands stable. Next state RUN, cnt=0.
- RUN:
  - mul_load=0; cnt increments each edge.
  - On the edge where cnt==MUL_LAT-1: rsp_prod<=mul_out, rsp_valid<=1, state DONE.
- DONE:
  - mul_load=1; rsp_valid, rsp_prod and rsp_id are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid<=0, state IDLE.
- Operand outputs: mul_mr/mul_md are unchanged from accept until the next accept.
- Latency: rsp_valid rises MUL_LAT+1 edges after the accept edge (6 for defaults).
- Throughput: minimum MUL_LAT+3 cycles per operation with rsp_ready held high.
- No new request is accepted before the response handshake completes.
- Arithmetic: two's-complement throughout. The product is passed through unmodified; no truncation or saturation.
- Boundary cases:
  - Requester drops valid while not granted: no effect; grant is recomputed every IDLE cycle.
  - Valid raised during LOAD/RUN/DONE: ready stays 0, request waits.
  - rsp_ready held low indefinitely: remain in DONE, outputs frozen, multiplier held in load.
  - rsp_ready high before rsp_valid: ignored.
  - Reset mid-operation (any state): immediate return to reset values. The in-flight operation is discarded and no response is produced.
  - Continuous requests from both requesters: strict alternation 0,1,0,1...; neither requester is starved.

Test Plan:
- Single op: req0 mr=7, md=5, rsp_ready=1 -> rsp_valid 6 cycles after accept; rsp_prod=8'h23 (35), rsp_id=0; mul_load low for exactly 5 cycles.
- Signed op: req1 mr=3, md=-5 (4'b1011) -> rsp_prod=8'hF1 (-15), rsp_id=1.
- Corner values: mr=-8, md=-8 -> 8'h40 (64); mr=-8, md=7 -> 8'hC8 (-56); mr=0, md=-1 -> 8'h00.
- Contention: both requesters valid continuously from reset, rsp_ready=1:
  - Grants go req0, req1, req0, req1.
  - Results are tagged with the correct ids.
  - Each ready is a single-cycle pulse, never both high together.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid/rsp_prod stable, busy=1, no ready pulse; on rsp_ready=1, handshake completes and IDLE follows.
- Reset mid-RUN: assert rst=0 at cnt=2 -> all outputs take reset values asynchronously, no response appears; a fresh request after release completes correctly.
